// File: rtl/gg_ser8_tx.sv
// Byte serializer for the 8-bit serial link: start, 8 data bits LSB-first, optional parity, stop.
// Define GG_SER8_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module gg_ser8_tx #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DIVW  = 8,
  parameter int          Dck_q = 1
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic [7:0] D,
  input  logic       LD,
  output logic       RDY,
  output logic       BUSY,
  output logic       TXD,
  output logic       DONE
);

  localparam int unsigned SW = 3;
  localparam int unsigned BW = 3;

  // Elaboration-time guard on the divider range; Dck_q only matters to gate-level timing models.
  if (DIV < 1 || DIV >= (2 ** DIVW) || Dck_q < 0) begin : g_bad_cfg
    $error("gg_ser8_tx: DIV must be in 1..2**DIVW-1");
  end

  typedef enum logic [SW-1:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef GG_SER8_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [7:0]      sreg_q, sreg_d;
`ifdef GG_SER8_PARITY_EN
  logic            par_q, par_d;
`endif
  logic            txd_q, txd_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_c;

  assign last_c = (cnt_q == DIVW'(DIV - 1));

  // State and registered outputs
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
`ifdef GG_SER8_PARITY_EN
      par_q   <= 1'b0;
`endif
      txd_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
`ifdef GG_SER8_PARITY_EN
      par_q   <= par_d;
`endif
      txd_q   <= txd_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: every non-idle state lasts DIV cycles, advancing when the divider hits DIV-1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
`ifdef GG_SER8_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) begin
      cnt_d = last_c ? '0 : cnt_q + DIVW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (LD === 1'b1) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          sreg_d  = D;
`ifdef GG_SER8_PARITY_EN
          par_d   = ^D;
`endif
        end
      end
      S_START: begin
        if (last_c) state_d = S_DATA;
      end
      S_DATA: begin
        if (last_c) begin
          sreg_d = {1'b0, sreg_q[7:1]};
          bit_d  = bit_q + BW'(1);
          if (bit_q == BW'(7)) begin
`ifdef GG_SER8_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef GG_SER8_PARITY_EN
      S_PARITY: begin
        if (last_c) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (last_c) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the cycle that follows this edge
  always_comb begin
    txd_d  = 1'b1;
    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && last_c;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = sreg_d[0];
`ifdef GG_SER8_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  assign TXD  = txd_q;
  assign RDY  = rdy_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_gg_ser8_tx.sv
// Directed bench for gg_ser8_tx: table of bytes with hand-computed frames plus reset/back-to-back/abort sequences.
module tb_gg_ser8_tx;

  localparam int unsigned DIV = 4;
`ifdef GG_SER8_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CK;
  logic       CLR;
  logic [7:0] D;
  logic       LD;
  logic       RDY;
  logic       BUSY;
  logic       TXD;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  gg_ser8_tx #(.DIV(DIV), .DIVW(8), .Dck_q(1)) dut (
    .CK(CK), .CLR(CLR), .D(D), .LD(LD),
    .RDY(RDY), .BUSY(BUSY), .TXD(TXD), .DONE(DONE)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;  // {stop, data[7:0], start}, bit 0 sent first
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input vec_t v);
`ifdef GG_SER8_PARITY_EN
    return {1'b1, v.par, v.frame[8:0]};
`else
    return {1'b0, v.frame};
`endif
  endfunction

  // Called at the negedge right after the accept edge; ends at the DONE cycle's negedge.
  task automatic check_frame(input logic [10:0] f, input int ld_c, input logic hold_ld,
                             input logic [7:0] next_d);
    for (int c = 0; c <= NB * int'(DIV); c++) begin
      if (c > 0) @(negedge CK);
      if (c < NB * int'(DIV)) begin
        chk("txd_bit", TXD, f[c / int'(DIV)]);
        chk("rdy_busy", RDY, 1'b0);
        chk("busy_busy", BUSY, 1'b1);
        chk("done_early", DONE, 1'b0);
      end else begin
        chk("txd_end", TXD, 1'b1);
        chk("rdy_end", RDY, 1'b1);
        chk("busy_end", BUSY, 1'b0);
        chk("done_pulse", DONE, 1'b1);
      end
      if (c == 0) begin
        D  = next_d;
        LD = hold_ld;
      end
      if (ld_c > 0) begin
        if (c == ld_c) LD = 1'b1;
        else if (c == ld_c + 1) LD = 1'b0;
      end
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge CK);
    chk("rdy_before_ld", RDY, 1'b1);
    D  = d;
    LD = 1'b1;
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CK);
      chk("idle_txd", TXD, 1'b1);
      chk("idle_rdy", RDY, 1'b1);
      chk("idle_done", DONE, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h3C, 10'h278, 1'b0};
    vecs[2] = '{8'h00, 10'h200, 1'b0};
    vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[4] = '{8'h07, 10'h20E, 1'b1};
    vecs[5] = '{8'h03, 10'h206, 1'b0};
    vecs[6] = '{8'h80, 10'h300, 1'b1};
    vecs[7] = '{8'h11, 10'h222, 1'b0};

    // Reset held with LD asserted and clock running
    CLR = 1'b0;
    LD  = 1'b1;
    D   = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge CK);
      chk("rst_txd", TXD, 1'b1);
      chk("rst_rdy", RDY, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
    end
    LD  = 1'b0;
    CLR = 1'b1;
    check_idle(2);

    // Table of frames, each checked bit by bit; D is scrambled after accept
    foreach (vecs[i]) begin
      start_frame(vecs[i].d);
      check_frame(mkframe(vecs[i]), 0, 1'b0, ~vecs[i].d);
    end
    check_idle(2);

    // LD pulsed mid-frame is ignored
    start_frame(8'h3C);
    check_frame(mkframe(vecs[1]), 5, 1'b0, 8'hFF);
    check_idle(3 * int'(DIV));

    // LD held high: two contiguous frames, second start the cycle after DONE
    start_frame(8'h11);
    check_frame(mkframe(vecs[7]), 0, 1'b1, 8'h22);
    @(posedge CK);
    @(negedge CK);
    check_frame({1'b1, 1'b0, 9'h044} | ((NB == 10) ? 11'h200 : 11'h000) & 11'h3FF
                  | ((NB == 11) ? 11'h400 : 11'h000), 0, 1'b0, 8'h00);
    check_idle(2);

    // Async reset during data bit 3 aborts the frame with no DONE
    start_frame(8'hA5);
    LD = 1'b0;
    for (int c = 0; c <= 4 * int'(DIV) + 1; c++) begin
      if (c > 0) @(negedge CK);
      chk("abort_pre_txd", TXD, mkframe(vecs[0])[c / int'(DIV)]);
    end
    CLR = 1'b0;
    #1;
    chk("abort_txd", TXD, 1'b1);
    chk("abort_rdy", RDY, 1'b1);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    @(negedge CK);
    CLR = 1'b1;
    check_idle(12 * int'(DIV));
    start_frame(8'h3C);
    check_frame(mkframe(vecs[1]), 0, 1'b0, 8'h00);
    check_idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
